// File: rtl/lz77_pkg.sv
// Shared LZ77 token definitions used by both the compressor and decompressor:
// header field positions, flag values, default match bias and decoder state encoding.
package lz77_pkg;

  localparam int TOK_FLAG_BIT  = 7;
  localparam int TOK_LEN_MSB   = 6;
  localparam int TOK_LEN_LSB   = 4;
  localparam int TOK_DHI_MSB   = 3;
  localparam int LIT_CNT_MSB   = 6;
  localparam int MIN_MATCH_DEF = 3;

  localparam logic TOK_LITERAL = 1'b0;
  localparam logic TOK_MATCH   = 1'b1;

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_LIT   = 2'd1,
    ST_MDIST = 2'd2,
    ST_MCOPY = 2'd3
  } lz77_state_e;

  // Match length carried by a match header byte, including the bias.
  function automatic logic [7:0] match_len(input logic [7:0] hdr, input int min_match);
    logic [7:0] base;
    base = {5'd0, hdr[TOK_LEN_MSB:TOK_LEN_LSB]};
    return base + 8'(min_match);
  endfunction

endpackage

// File: rtl/lz77_decompress_if.sv
// Compressed-byte input stream, decoded-byte output stream and decoder status.
// The slave side is the decoder; the master side is its environment.
interface lz77_decompress_if;
  logic       i_en;
  logic       i_rdy;
  logic [7:0] i_data;
  logic       o_en;
  logic       o_rdy;
  logic [7:0] o_data;
  logic       o_err;
  logic       o_idle;

  modport master (
    output i_en, i_data, o_rdy,
    input  i_rdy, o_en, o_data, o_err, o_idle
  );

  modport slave (
    input  i_en, i_data, o_rdy,
    output i_rdy, o_en, o_data, o_err, o_idle
  );
endinterface

// File: rtl/lz77_hist_ram.sv
// History window RAM: one write port, one synchronous read port with enable.
// Read-during-write to the same address returns the old contents.
module lz77_hist_ram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [0:(1<<AW)-1];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/lz77_decompress.sv
// Streaming LZ77 token decoder: literal runs pass straight through, matches are
// replayed from a 2^WAW-byte history RAM through a one-deep read pipeline.
module lz77_decompress
  import lz77_pkg::*;
#(
  parameter int WAW       = 12,
  parameter int MIN_MATCH = MIN_MATCH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  lz77_decompress_if.slave bus
);

  localparam int            CW        = WAW + 1;
  localparam logic [CW-1:0] WIN_BYTES = CW'(1) << WAW;

  lz77_state_e    state_q, state_d;
  logic [6:0]     lit_cnt_q, lit_cnt_d;
  logic [3:0]     dist_hi_q, dist_hi_d;
  logic [7:0]     rem_q, rem_d;
  logic [WAW-1:0] rd_ptr_q, rd_ptr_d;
  logic           rd_pend_q, rd_pend_d;
  logic [CW-1:0]  offset_q, offset_d;
  logic [WAW-1:0] wptr_q, wptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           o_en_q, o_en_d;
  logic [7:0]     o_data_q, o_data_d;
  logic           err_q, err_d;
  logic           fwd_q, fwd_d;
  logic [7:0]     fwd_data_q, fwd_data_d;

  logic           adv;
  logic           i_rdy;
  logic           acc;
  logic           emit;
  logic           rd_en;
  logic           consume;
  logic           issue;
  logic [7:0]     emit_data;
  logic [7:0]     ram_rd_data;
  logic [7:0]     copy_byte;
  logic [11:0]    dist_full;
  logic [WAW-1:0] dist_field;

  assign dist_full  = {dist_hi_q, bus.i_data};
  assign dist_field = dist_full[WAW-1:0];

  always_comb begin
    state_d    = state_q;
    lit_cnt_d  = lit_cnt_q;
    dist_hi_d  = dist_hi_q;
    rem_d      = rem_q;
    rd_ptr_d   = rd_ptr_q;
    rd_pend_d  = rd_pend_q;
    offset_d   = offset_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    o_en_d     = o_en_q;
    o_data_d   = o_data_q;
    err_d      = err_q;
    fwd_d      = fwd_q;
    fwd_data_d = fwd_data_q;
    emit       = 1'b0;
    emit_data  = 8'h00;
    rd_en      = 1'b0;
    consume    = 1'b0;
    issue      = 1'b0;
    // A byte issued while its source was being written comes from the bypass.
    copy_byte  = fwd_q ? fwd_data_q : ram_rd_data;
    adv        = !o_en_q || bus.o_rdy;

    case (state_q)
      ST_HDR, ST_MDIST: i_rdy = 1'b1;
      ST_LIT:           i_rdy = adv;
      default:          i_rdy = 1'b0;
    endcase
    i_rdy = i_rdy && !rst;
    acc   = bus.i_en && i_rdy;

    case (state_q)
      ST_HDR: begin
        if (acc) begin
          if (bus.i_data[TOK_FLAG_BIT] == TOK_LITERAL) begin
            lit_cnt_d = bus.i_data[LIT_CNT_MSB:0];
            state_d   = ST_LIT;
          end else if (bus.i_data[TOK_FLAG_BIT] == TOK_MATCH) begin
            dist_hi_d = bus.i_data[TOK_DHI_MSB:0];
            rem_d     = match_len(bus.i_data, MIN_MATCH);
            state_d   = ST_MDIST;
          end
        end
      end
      ST_LIT: begin
        if (acc) begin
          emit      = 1'b1;
          emit_data = bus.i_data;
          if (lit_cnt_q == 7'd0) begin
            state_d = ST_HDR;
          end else begin
            lit_cnt_d = lit_cnt_q - 7'd1;
          end
        end
      end
      ST_MDIST: begin
        if (acc) begin
          offset_d  = {1'b0, dist_field} + CW'(1);
          rd_ptr_d  = wptr_q - dist_field - WAW'(1);
          rd_pend_d = 1'b0;
          state_d   = ST_MCOPY;
        end
      end
      ST_MCOPY: begin
        consume = rd_pend_q && adv;
        issue   = (rem_q != 8'd0) && (!rd_pend_q || consume);
        if (consume) begin
          emit = 1'b1;
          if (offset_q <= count_q) begin
            emit_data = copy_byte;
          end else begin
            emit_data = 8'h00;
            err_d     = 1'b1;
          end
        end
        if (issue) begin
          rd_en    = 1'b1;
          rd_ptr_d = rd_ptr_q + WAW'(1);
          rem_d    = rem_q - 8'd1;
        end
        rd_pend_d = issue || (rd_pend_q && !consume);
        if (consume && (rem_q == 8'd0)) begin
          state_d = ST_HDR;
        end
      end
      default: state_d = ST_HDR;
    endcase

    if (rd_en) begin
      fwd_d      = emit && (rd_ptr_q == wptr_q);
      fwd_data_d = emit_data;
    end

    if (emit) begin
      o_en_d   = 1'b1;
      o_data_d = emit_data;
      wptr_d   = wptr_q + WAW'(1);
      if (count_q != WIN_BYTES) begin
        count_d = count_q + CW'(1);
      end
    end else if (adv) begin
      o_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HDR;
      lit_cnt_q  <= '0;
      dist_hi_q  <= '0;
      rem_q      <= '0;
      rd_ptr_q   <= '0;
      rd_pend_q  <= 1'b0;
      offset_q   <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      o_en_q     <= 1'b0;
      o_data_q   <= 8'h00;
      err_q      <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      lit_cnt_q  <= lit_cnt_d;
      dist_hi_q  <= dist_hi_d;
      rem_q      <= rem_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_pend_q  <= rd_pend_d;
      offset_q   <= offset_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      o_en_q     <= o_en_d;
      o_data_q   <= o_data_d;
      err_q      <= err_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  lz77_hist_ram #(.AW(WAW)) u_hist (
    .clk     (clk),
    .wr_en   (emit),
    .wr_addr (wptr_q),
    .wr_data (emit_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

  assign bus.i_rdy  = i_rdy;
  assign bus.o_en   = o_en_q;
  assign bus.o_data = o_data_q;
  assign bus.o_err  = err_q;
  assign bus.o_idle = (state_q == ST_HDR) && !o_en_q;

endmodule

// File: tb/tb_lz77_decompress.sv
// Bench for lz77_decompress: constant vector table, hand-built corner sequences and
// random token streams checked against a queue-based token decoder model.
module tb_lz77_decompress;

  localparam int WAW   = 12;
  localparam int MINM  = 3;
  localparam int WIN   = 1 << WAW;
  localparam int LIMIT = 20000;
  localparam int NV    = 6;

  typedef struct packed {
    logic [63:0]  in_w;
    logic [7:0]   n_in;
    logic [127:0] exp_w;
    logic [7:0]   n_exp;
    logic         exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lz77_decompress_if bus ();

  lz77_decompress #(.WAW(WAW), .MIN_MATCH(MINM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] stim_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] lit_q[$];
  int         stamp_q[$];
  logic       exp_err;
  vec_t       vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic do_reset(input string tag);
    rst        = 1'b1;
    bus.i_en   = 1'b1;
    bus.i_data = 8'h00;
    bus.o_rdy  = 1'b1;
    @(negedge clk);
    check({tag, ":i_rdy_in_reset"}, 32'(bus.i_rdy), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst      = 1'b0;
    bus.i_en = 1'b0;
    @(negedge clk);
    check({tag, ":rst_o_en"},   32'(bus.o_en),   32'd0);
    check({tag, ":rst_o_data"}, 32'(bus.o_data), 32'd0);
    check({tag, ":rst_o_err"},  32'(bus.o_err),  32'd0);
    check({tag, ":rst_o_idle"}, 32'(bus.o_idle), 32'd1);
    @(posedge clk); #1;
  endtask

  // Feeds stim_q and collects outputs until all input is taken and n_exp bytes seen.
  task automatic drive(input int n_exp, input int rdy_pct, input int gap_pct, input string tag);
    int idx = 0;
    int cyc = 0;
    got_q.delete();
    stamp_q.delete();
    while ((idx < stim_q.size() || got_q.size() < n_exp) && cyc < LIMIT) begin
      bus.i_en   = (idx < stim_q.size()) && ($urandom_range(99) >= gap_pct);
      bus.i_data = bus.i_en ? stim_q[idx] : 8'h00;
      bus.o_rdy  = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (bus.i_en && bus.i_rdy) idx++;
      if (bus.o_en && bus.o_rdy) begin
        got_q.push_back(bus.o_data);
        stamp_q.push_back(cyc);
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.i_en  = 1'b0;
    bus.o_rdy = 1'b0;
    checks++;
    if (cyc >= LIMIT) begin
      failures++;
      $display("FAIL %s:timeout inputs %0d/%0d outputs %0d/%0d", tag, idx, stim_q.size(),
               got_q.size(), n_exp);
    end
  endtask

  task automatic drain_check(input string tag, input logic req_err, input logic req_idle);
    int extra = 0;
    bus.i_en  = 1'b0;
    bus.o_rdy = 1'b1;
    repeat (16) begin
      @(negedge clk);
      if (bus.o_en) extra++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({tag, ":extra_bytes"}, 32'(extra),       32'd0);
    check({tag, ":o_err"},       32'(bus.o_err),  32'(req_err));
    check({tag, ":o_idle"},      32'(bus.o_idle), 32'(req_idle));
    @(posedge clk); #1;
  endtask

  task automatic compare_seq(input string tag);
    int bad = -1;
    check({tag, ":count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      if (bad < 0 && got_q[k] !== exp_q[k]) bad = k;
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s:data byte %0d got %02h required %02h", tag, bad, got_q[bad], exp_q[bad]);
    end
  endtask

  // Reference decoder: walks tokens and copies from the full output history.
  task automatic model_decode();
    int p;
    int len;
    int off;
    int n;
    logic [7:0] h;
    logic [7:0] d;
    p = 0;
    exp_q.delete();
    exp_err = 1'b0;
    while (p < stim_q.size()) begin
      h = stim_q[p];
      p++;
      if (h[7] == 1'b0) begin
        for (int k = 0; k <= int'(h[6:0]); k++) begin
          exp_q.push_back(stim_q[p]);
          p++;
        end
      end else begin
        d = stim_q[p];
        p++;
        len = int'(h[6:4]) + MINM;
        off = (int'({h[3:0], d}) % WIN) + 1;
        for (int k = 0; k < len; k++) begin
          n = exp_q.size();
          if (off > n) begin
            exp_q.push_back(8'h00);
            exp_err = 1'b1;
          end else begin
            exp_q.push_back(exp_q[n - off]);
          end
        end
      end
    end
  endtask

  task automatic run_model(input string tag, input int rdy_pct, input int gap_pct);
    model_decode();
    drive(exp_q.size(), rdy_pct, gap_pct, tag);
    compare_seq(tag);
    drain_check(tag, exp_err, 1'b1);
    $display("%s: in=%0d out=%0d err=%0b", tag, stim_q.size(), got_q.size(), exp_err);
  endtask

  initial begin
    int   ni;
    int   ne;
    int   n;
    int   len;
    int   lf;
    int   maxo;
    int   off;
    int   chunk;
    logic [11:0] field;
    logic [7:0]  b;
    string tag;

    rst        = 1'b1;
    bus.i_en   = 1'b0;
    bus.i_data = 8'h00;
    bus.o_rdy  = 1'b0;

    vecs[0] = '{64'h02414243,     8'd4, 128'h414243,                   8'd3,  1'b0};
    vecs[1] = '{64'h00618000,     8'd4, 128'h61616161,                 8'd4,  1'b0};
    vecs[2] = '{64'h016162F001,   8'd5, 128'h616261626162616261626162, 8'd12, 1'b0};
    vecs[3] = '{64'h8004,         8'd2, 128'h000000,                   8'd3,  1'b1};
    vecs[4] = '{64'h024142439002, 8'd6, 128'h41424341424341,           8'd7,  1'b0};
    vecs[5] = '{64'h00558001,     8'd4, 128'h55005500,                 8'd4,  1'b1};

    for (int v = 0; v < NV; v++) begin
      for (int pass = 0; pass < 2; pass++) begin
        tag = $sformatf("vec%0d/p%0d", v, pass);
        do_reset(tag);
        ni = int'(vecs[v].n_in);
        ne = int'(vecs[v].n_exp);
        stim_q.delete();
        exp_q.delete();
        for (int k = 0; k < ni; k++) stim_q.push_back(vecs[v].in_w[8*(ni-1-k) +: 8]);
        for (int k = 0; k < ne; k++) exp_q.push_back(vecs[v].exp_w[8*(ne-1-k) +: 8]);
        drive(ne, (pass == 0) ? 100 : 70, (pass == 0) ? 0 : 20, tag);
        compare_seq(tag);
        drain_check(tag, vecs[v].exp_err, 1'b1);
        if (v == 1 && pass == 0) begin
          if (stamp_q.size() >= 4) check("vec1:copy_rate", 32'(stamp_q[3] - stamp_q[1]), 32'd2);
          else                     check("vec1:copy_rate", 32'(stamp_q.size()), 32'd4);
        end
        $display("%s: in=%0d out=%0d err=%0b", tag, ni, got_q.size(), vecs[v].exp_err);
      end
    end

    // Error stays set while decoding continues.
    do_reset("sticky");
    stim_q = '{8'h80, 8'h04, 8'h00, 8'h11};
    run_model("sticky", 100, 0);

    // Truncated token then reset: pending history must be forgotten.
    do_reset("trunc");
    stim_q = '{8'h02, 8'h41};
    exp_q  = '{8'h41};
    drive(1, 100, 0, "trunc");
    compare_seq("trunc");
    drain_check("trunc", 1'b0, 1'b0);
    $display("trunc: in=%0d out=%0d", stim_q.size(), got_q.size());
    do_reset("after_trunc");
    stim_q = '{8'h00, 8'h7A, 8'h80, 8'h01};
    run_model("after_trunc", 80, 10);

    // Window wrap: a full-window offset reaches back to literal index 4.
    do_reset("wrap");
    stim_q.delete();
    lit_q.delete();
    n = 0;
    while (n < 4100) begin
      chunk = (4100 - n > 128) ? 128 : (4100 - n);
      stim_q.push_back(8'(chunk - 1));
      for (int k = 0; k < chunk; k++) begin
        b = 8'($urandom_range(255));
        stim_q.push_back(b);
        lit_q.push_back(b);
      end
      n += chunk;
    end
    stim_q.push_back(8'hFF);
    stim_q.push_back(8'hFF);
    run_model("wrap", 100, 0);
    check("wrap:first_copy", 32'((got_q.size() > 4100) ? got_q[4100] : 8'hxx), 32'(lit_q[4]));
    check("wrap:last_copy",  32'((got_q.size() > 4109) ? got_q[4109] : 8'hxx), 32'(lit_q[13]));

    // Random token streams with stalls on both sides.
    for (int r = 0; r < 12; r++) begin
      tag = $sformatf("rand%0d", r);
      do_reset(tag);
      stim_q.delete();
      n = 0;
      while (n < 150) begin
        if (n == 0 || $urandom_range(99) < 45) begin
          len = ($urandom_range(9) == 0) ? int'($urandom_range(128, 100)) : int'($urandom_range(12, 1));
          stim_q.push_back(8'(len - 1));
          for (int k = 0; k < len; k++) stim_q.push_back(8'($urandom_range(255)));
          n += len;
        end else begin
          lf   = int'($urandom_range(7));
          maxo = (n < WIN) ? n : WIN;
          if ($urandom_range(9) == 0) off = n + int'($urandom_range(8, 1));
          else                        off = int'($urandom_range(maxo, 1));
          if (off > WIN) off = WIN;
          field = 12'(off - 1);
          stim_q.push_back({1'b1, 3'(lf), field[11:8]});
          stim_q.push_back(field[7:0]);
          n += lf + MINM;
        end
      end
      run_model(tag, int'($urandom_range(100, 40)), int'($urandom_range(40, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
